// File: rtl/evt_decoder_pipe.sv
// evt_decoder_pipe
// Registered event-to-datapath decoder. Each accepted spike event has its
// operation translated through a runtime-programmable map table. The map can
// either produce a datapath op or discard the event. Surviving events pass
// through a 2-entry buffer that has valid/ready handshakes on both sides.
// Saturating per-operation and drop counters run alongside.
//
// The buffer is a head register plus one tail (skid) register:
//   - The head register drives the dp_* outputs directly, so those outputs
//     are registered.
//   - When the head is popped and nothing replaces it, the head keeps its
//     last contents.
// evt_ready_o depends only on registered occupancy, so no combinational
// path exists from dp_ready_i to evt_ready_o.

module evt_decoder_pipe #(
    parameter int OP_W      = 3,
    parameter int DPOP_W    = 3,
    parameter int PAYLOAD_W = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_map_we_i,
    input  logic [OP_W-1:0]      cfg_map_addr_i,
    input  logic [DPOP_W:0]      cfg_map_data_i,
    input  logic                 cfg_cnt_clr_i,
    input  logic                 evt_valid_i,
    output logic                 evt_ready_o,
    input  logic [OP_W-1:0]      evt_op_i,
    input  logic [PAYLOAD_W-1:0] evt_payload_i,
    output logic                 dp_valid_o,
    input  logic                 dp_ready_i,
    output logic [DPOP_W-1:0]    dp_op_o,
    output logic [PAYLOAD_W-1:0] dp_payload_o,
    input  logic [OP_W-1:0]      cnt_sel_i,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o,
    output logic                 busy_o
);

    localparam int              MAP_N   = 2 ** OP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Map table: bit DPOP_W is the drop flag, the low bits are the datapath op.
    logic [DPOP_W:0]      map_r [MAP_N];

    // Head entry (drives the outputs) and tail entry of the 2-deep buffer.
    logic                 head_valid_r;
    logic [DPOP_W-1:0]    head_op_r;
    logic [PAYLOAD_W-1:0] head_payload_r;
    logic                 tail_valid_r;
    logic [DPOP_W-1:0]    tail_op_r;
    logic [PAYLOAD_W-1:0] tail_payload_r;

    // Statistics counters.
    logic [CNT_W-1:0]     op_cnt_r [MAP_N];
    logic [CNT_W-1:0]     drop_cnt_r;

    // Per-cycle decode of the handshake and map lookup.
    logic [DPOP_W:0]      map_entry_s;
    logic                 evt_ready_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 drop_evt_s;
    logic                 pop_s;

    // Handshake decode.
    // The lookup reads the registered map, so a same-cycle cfg write is not
    // yet visible (read-before-write). Every qualifier includes evt_valid_i,
    // so op/payload are don't-care while the input is idle.
    always_comb begin
        map_entry_s = map_r[evt_op_i];
        evt_ready_s = !(head_valid_r && tail_valid_r);
        pop_s       = head_valid_r && dp_ready_i;
        if (evt_valid_i && evt_ready_s) begin
            accept_s   = 1'b1;
            push_s     = !map_entry_s[DPOP_W];
            drop_evt_s = map_entry_s[DPOP_W];
        end else begin
            accept_s   = 1'b0;
            push_s     = 1'b0;
            drop_evt_s = 1'b0;
        end
    end

    // Map table.
    // Reset loads identity (truncating or zero-extending the index).
    // Otherwise the table takes cfg writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < MAP_N; k++) begin
                map_r[k] <= {1'b0, DPOP_W'(k)};
            end
        end else if (cfg_map_we_i) begin
            map_r[cfg_map_addr_i] <= cfg_map_data_i;
        end else begin
            map_r <= map_r;
        end
    end

    // Two-entry buffer. A push while the tail is occupied cannot occur,
    // because evt_ready_s is low whenever both entries are full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_valid_r   <= 1'b0;
            head_op_r      <= {DPOP_W{1'b0}};
            head_payload_r <= {PAYLOAD_W{1'b0}};
            tail_valid_r   <= 1'b0;
            tail_op_r      <= {DPOP_W{1'b0}};
            tail_payload_r <= {PAYLOAD_W{1'b0}};
        end else if (!head_valid_r || pop_s) begin
            // The head slot is free this cycle: refill from the tail first
            // (oldest event), otherwise from the incoming event.
            if (tail_valid_r) begin
                head_valid_r   <= 1'b1;
                head_op_r      <= tail_op_r;
                head_payload_r <= tail_payload_r;
                tail_valid_r   <= 1'b0;
            end else if (push_s) begin
                head_valid_r   <= 1'b1;
                head_op_r      <= map_entry_s[DPOP_W-1:0];
                head_payload_r <= evt_payload_i;
            end else begin
                // Drained: the data fields keep their last emitted values.
                head_valid_r   <= 1'b0;
            end
        end else if (push_s) begin
            // The head is stalled downstream, so park the new event in the tail.
            tail_valid_r   <= 1'b1;
            tail_op_r      <= map_entry_s[DPOP_W-1:0];
            tail_payload_r <= evt_payload_i;
        end else begin
            tail_valid_r   <= tail_valid_r;
        end
    end

    // Saturating statistics counters.
    // A clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_cnt_clr_i) begin
            for (int k = 0; k < MAP_N; k++) begin
                op_cnt_r[k] <= {CNT_W{1'b0}};
            end
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            for (int k = 0; k < MAP_N; k++) begin
                if (accept_s && (evt_op_i == OP_W'(k)) && (op_cnt_r[k] != CNT_MAX)) begin
                    op_cnt_r[k] <= op_cnt_r[k] + CNT_W'(1);
                end else begin
                    op_cnt_r[k] <= op_cnt_r[k];
                end
            end
            if (drop_evt_s && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign evt_ready_o  = evt_ready_s;
    assign dp_valid_o   = head_valid_r;
    assign dp_op_o      = head_op_r;
    assign dp_payload_o = head_payload_r;
    assign busy_o       = head_valid_r;
    assign cnt_o        = op_cnt_r[cnt_sel_i];
    assign drop_cnt_o   = drop_cnt_r;

endmodule

// File: tb/tb_evt_decoder_pipe.sv
// Self-checking bench for evt_decoder_pipe.
// A queue-based reference model predicts every output each cycle. Directed
// steps follow the test plan, and a randomized phase follows them. The DUT
// uses CNT_W=4 so that counter saturation is reachable.

module tb_evt_decoder_pipe;

    localparam int OP_W      = 3;
    localparam int DPOP_W    = 3;
    localparam int PAYLOAD_W = 32;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 cfg_map_we_i;
    logic [OP_W-1:0]      cfg_map_addr_i;
    logic [DPOP_W:0]      cfg_map_data_i;
    logic                 cfg_cnt_clr_i;
    logic                 evt_valid_i;
    logic                 evt_ready_o;
    logic [OP_W-1:0]      evt_op_i;
    logic [PAYLOAD_W-1:0] evt_payload_i;
    logic                 dp_valid_o;
    logic                 dp_ready_i;
    logic [DPOP_W-1:0]    dp_op_o;
    logic [PAYLOAD_W-1:0] dp_payload_o;
    logic [OP_W-1:0]      cnt_sel_i;
    logic [CNT_W-1:0]     cnt_o;
    logic [CNT_W-1:0]     drop_cnt_o;
    logic                 busy_o;

    evt_decoder_pipe #(
        .OP_W(OP_W), .DPOP_W(DPOP_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_map_we_i(cfg_map_we_i), .cfg_map_addr_i(cfg_map_addr_i),
        .cfg_map_data_i(cfg_map_data_i), .cfg_cnt_clr_i(cfg_cnt_clr_i),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
        .evt_op_i(evt_op_i), .evt_payload_i(evt_payload_i),
        .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i),
        .dp_op_o(dp_op_o), .dp_payload_o(dp_payload_o),
        .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o),
        .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    typedef struct packed {
        logic [DPOP_W-1:0]    op;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    ent_t                 q[$];
    logic                 m_drop [8];
    logic [DPOP_W-1:0]    m_op [8];
    int                   m_cnt [8];
    int                   m_drop_cnt;
    logic [DPOP_W-1:0]    last_op;
    logic [PAYLOAD_W-1:0] last_pl;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 8; k++) begin
            m_drop[k] = 1'b0;
            m_op[k]   = 3'(k);
            m_cnt[k]  = 0;
        end
        m_drop_cnt = 0;
        last_op    = '0;
        last_pl    = '0;
    endtask

    task automatic check_outputs();
        logic [DPOP_W-1:0]    eop;
        logic [PAYLOAD_W-1:0] epl;
        eop = (q.size() > 0) ? q[0].op : last_op;
        epl = (q.size() > 0) ? q[0].pl : last_pl;
        chk("evt_ready", 64'(evt_ready_o), 64'(q.size() != 2));
        chk("dp_valid",  64'(dp_valid_o),  64'(q.size() != 0));
        chk("busy",      64'(busy_o),      64'(q.size() != 0));
        chk("dp_op",     64'(dp_op_o),     64'(eop));
        chk("dp_payload",64'(dp_payload_o),64'(epl));
        chk("cnt",       64'(cnt_o),       64'(m_cnt[cnt_sel_i]));
        chk("drop_cnt",  64'(drop_cnt_o),  64'(m_drop_cnt));
    endtask

    // Apply one rising edge to the model, using the inputs as currently driven.
    task automatic model_edge();
        bit   acc;
        ent_t e;
        if (rst_i) begin
            model_reset();
            return;
        end
        acc = evt_valid_i && (q.size() != 2);
        if (q.size() > 0 && dp_ready_i) begin
            last_op = q[0].op;
            last_pl = q[0].pl;
            void'(q.pop_front());
        end
        if (acc) begin
            if (m_drop[evt_op_i]) begin
                if (m_drop_cnt < CNT_MAX) m_drop_cnt++;
            end else begin
                e.op = m_op[evt_op_i];
                e.pl = evt_payload_i;
                q.push_back(e);
            end
        end
        if (cfg_cnt_clr_i) begin
            for (int k = 0; k < 8; k++) m_cnt[k] = 0;
            m_drop_cnt = 0;
        end else if (acc && m_cnt[evt_op_i] < CNT_MAX) begin
            m_cnt[evt_op_i]++;
        end
        if (cfg_map_we_i) begin
            m_drop[cfg_map_addr_i] = cfg_map_data_i[DPOP_W];
            m_op[cfg_map_addr_i]   = cfg_map_data_i[DPOP_W-1:0];
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, then return shortly after it so the caller can drive new inputs.
    task automatic cycle();
        @(negedge clk_i);
        check_outputs();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [OP_W-1:0] op, input logic [PAYLOAD_W-1:0] pl);
        evt_valid_i   = 1'b1;
        evt_op_i      = op;
        evt_payload_i = pl;
    endtask

    task automatic idle_evt();
        evt_valid_i   = 1'b0;
        evt_op_i      = 3'($urandom);
        evt_payload_i = $urandom;
    endtask

    initial begin
        rst_i          = 1'b1;
        cfg_map_we_i   = 1'b0;
        cfg_map_addr_i = 3'd0;
        cfg_map_data_i = 4'd0;
        cfg_cnt_clr_i  = 1'b0;
        dp_ready_i     = 1'b1;
        cnt_sel_i      = 3'd0;
        idle_evt();
        @(posedge clk_i);
        model_reset();
        #1;
        cycle();
        rst_i = 1'b0;
        cycle();

        // Single event goes through with one cycle of latency.
        cnt_sel_i = 3'd2;
        send(3'd2, 32'hDEADBEEF);
        cycle();
        idle_evt();
        chk("t1_valid", 64'(dp_valid_o), 64'd1);
        chk("t1_op",    64'(dp_op_o), 64'd2);
        chk("t1_pl",    64'(dp_payload_o), 64'hDEADBEEF);
        chk("t1_cnt",   64'(cnt_o), 64'd1);
        cycle();

        // Remap op 1 to datapath op 4, then stream three events back-to-back.
        cfg_map_we_i   = 1'b1;
        cfg_map_addr_i = 3'd1;
        cfg_map_data_i = 4'b0100;
        cycle();
        cfg_map_we_i = 1'b0;
        send(3'd1, 32'hA);
        cycle();
        chk("t2_op_first", 64'(dp_op_o), 64'd4);
        chk("t2_pl_first", 64'(dp_payload_o), 64'hA);
        send(3'd1, 32'hB);
        cycle();
        send(3'd3, 32'hC);
        cycle();
        chk("t2_op_last", 64'(dp_op_o), 64'd3);
        idle_evt();
        repeat (3) cycle();

        // Backpressure: two events fill the buffer and the third waits.
        dp_ready_i = 1'b0;
        send(3'd5, 32'h1111);
        cycle();
        send(3'd6, 32'h2222);
        cycle();
        send(3'd7, 32'h3333);
        cycle();
        chk("t3_ready_low", 64'(evt_ready_o), 64'd0);
        cycle();
        dp_ready_i = 1'b1;
        cycle();
        dp_ready_i = 1'b0;
        chk("t3_ready_back", 64'(evt_ready_o), 64'd1);
        cycle();
        idle_evt();
        dp_ready_i = 1'b1;
        repeat (4) cycle();

        // Drop mapping: op 4 is discarded and counted.
        cfg_map_we_i   = 1'b1;
        cfg_map_addr_i = 3'd4;
        cfg_map_data_i = 4'b1010;
        cycle();
        cfg_map_we_i = 1'b0;
        cnt_sel_i    = 3'd4;
        for (int i = 0; i < 5; i++) begin
            send(3'd4, 32'(i));
            cycle();
        end
        idle_evt();
        cycle();
        chk("t4_drop_cnt", 64'(drop_cnt_o), 64'd5);
        chk("t4_op4_cnt",  64'(cnt_o), 64'd5);
        chk("t4_no_valid", 64'(dp_valid_o), 64'd0);

        // Saturation, then a clear that wins over a same-cycle increment.
        cnt_sel_i = 3'd0;
        for (int i = 0; i < 20; i++) begin
            send(3'd0, $urandom);
            cycle();
        end
        idle_evt();
        cycle();
        chk("t5_sat", 64'(cnt_o), 64'd15);
        send(3'd0, 32'h55);
        cfg_cnt_clr_i = 1'b1;
        cycle();
        cfg_cnt_clr_i = 1'b0;
        idle_evt();
        chk("t5_clr", 64'(cnt_o), 64'd0);
        cycle();

        // Reset mid-stream with a full buffer.
        dp_ready_i = 1'b0;
        cnt_sel_i  = 3'd1;
        send(3'd1, 32'h77);
        cycle();
        send(3'd2, 32'h88);
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        idle_evt();
        chk("t6_valid", 64'(dp_valid_o), 64'd0);
        chk("t6_busy",  64'(busy_o), 64'd0);
        chk("t6_ready", 64'(evt_ready_o), 64'd1);
        chk("t6_cnt",   64'(cnt_o), 64'd0);
        chk("t6_drop",  64'(drop_cnt_o), 64'd0);
        dp_ready_i = 1'b1;
        send(3'd4, 32'h99);
        cycle();
        idle_evt();
        chk("t6_map_identity", 64'(dp_op_o), 64'd4);
        chk("t6_map_valid",    64'(dp_valid_o), 64'd1);
        cycle();

        // Randomized traffic with occasional map writes, clears and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 60) send(3'($urandom), $urandom);
            else idle_evt();
            dp_ready_i   = ($urandom_range(0, 99) < 65);
            cnt_sel_i    = 3'($urandom);
            cfg_map_we_i = ($urandom_range(0, 99) < 6);
            cfg_map_addr_i = 3'($urandom);
            cfg_map_data_i = {($urandom_range(0, 3) == 0), 3'($urandom)};
            cfg_cnt_clr_i  = ($urandom_range(0, 99) < 2);
            rst_i          = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst_i         = 1'b0;
        cfg_map_we_i  = 1'b0;
        cfg_cnt_clr_i = 1'b0;
        idle_evt();
        dp_ready_i = 1'b1;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/evt_decoder_pipe.md
Name: evt_decoder_pipe

Overview:
- Parametrised, registered successor to the combinational event-to-datapath decoder.
- Accepts the spike event stream (operation code plus payload) and translates the operation through a runtime-programmable map table into a neuron datapath op. The map can also discard events.
- Emits the result through a 2-entry output buffer with valid/ready handshakes on both sides, and keeps saturating per-operation and drop statistics counters.
- Sits between the event stream crossbar and the 8x8 neuron datapath.

Parameters:
- OP_W, 3, width of the input event operation field; the map has 2**OP_W entries.
- DPOP_W, 3, width of the datapath op field.
- PAYLOAD_W, 32, width of the pass-through event payload.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cfg_map_we_i  in  1  map table write strobe.
- cfg_map_addr_i  in  OP_W  map entry index.
- cfg_map_data_i  in  DPOP_W+1  bit DPOP_W = drop flag; bits DPOP_W-1:0 = datapath op.
- cfg_cnt_clr_i  in  1  clears all statistics counters.
- evt_valid_i  in  1  input event valid.
- evt_ready_o  out  1  input event ready.
- evt_op_i  in  OP_W  input event operation.
- evt_payload_i  in  PAYLOAD_W  input event payload.
- dp_valid_o  out  1  datapath event valid.
- dp_ready_i  in  1  datapath event ready.
- dp_op_o  out  DPOP_W  mapped datapath op.
- dp_payload_o  out  PAYLOAD_W  payload, bit-exact copy of the input.
- cnt_sel_i  in  OP_W  selects which per-op counter appears on cnt_o.
- cnt_o  out  CNT_W  accepted-event count for op cnt_sel_i (combinational read).
- drop_cnt_o  out  CNT_W  count of dropped events.
- busy_o  out  1  high while the output buffer holds at least one entry.

Behaviour:
- Reset values:
  - Map entry k = {drop=0, op=k[DPOP_W-1:0]}; if DPOP_W > OP_W, zero-extend k instead.
  - Buffer empty; counters 0.
  - evt_ready_o=1, dp_valid_o=0, dp_op_o=0, dp_payload_o=0, busy_o=0.
  - Reset asserted mid-stream flushes buffered events without emitting them.
- Accept: an event is accepted on a rising edge where evt_valid_i && evt_ready_o.
  - The map lookup uses the map contents before any same-cycle cfg write, i.e. read-before-write.
- Non-dropped accepted event: written to the buffer tail with the mapped op and payload.
  - dp_valid_o rises on the next cycle when the buffer was empty, so latency is 1 cycle.
- Dropped accepted event (map drop=1): consumed and never emitted; drop_cnt_o increments.
- Buffer: 2-entry FIFO; order preserved; dp_* outputs driven from the head entry.
  - Pop happens on dp_valid_o && dp_ready_i.
- evt_ready_o = (occupancy != 2), derived from registered occupancy only.
  - There is no combinational path from dp_ready_i to evt_ready_o.
  - When full and popped in a cycle, evt_ready_o stays 0 that cycle and returns to 1 the next.
- Simultaneous push and pop: occupancy unchanged. Sustained throughput is 1 event/cycle when dp_ready_i is held high.
- Output stability: while dp_valid_o && !dp_ready_i, dp_op_o and dp_payload_o hold stable.
  - On pop to empty, dp_op_o and dp_payload_o keep their last values and dp_valid_o=0.
- Counters:
  - Per-op counter [evt_op_i] increments on every accepted event, dropped or not.
  - All counters saturate at 2**CNT_W-1 and do not wrap.
  - cfg_cnt_clr_i has priority over a same-cycle increment; the result is 0.
- Map write: takes effect from the next cycle. Events already in the buffer keep their previously mapped op.
- X-safety: evt_op_i and evt_payload_i are ignored when evt_valid_i=0.

Test Plan:
- Reset then single event op=2, payload=0xDEADBEEF, dp_ready_i=1 -> cycle+1: dp_valid_o=1, dp_op_o=2, payload 0xDEADBEEF; cnt_sel_i=2 gives cnt_o=1.
- Program map[1]={drop=0, op=4}; send ops 1,1,3 back-to-back, payloads 0xA,0xB,0xC -> outputs in order: ops 4,4,3, payloads 0xA,0xB,0xC.
- dp_ready_i=0; send 3 events -> first two accepted, evt_ready_o=0 from then on, third held. Raise dp_ready_i for 1 cycle -> evt_ready_o=1 the following cycle, third accepted, order intact.
- Program map[4] drop=1; send 5 events op=4 -> no dp_valid_o; drop_cnt_o=5; per-op counter for op 4 reads 5.
- CNT_W=4: send 20 events op=0 -> cnt_o saturates at 15. Assert cfg_cnt_clr_i together with an accepted op=0 event -> counter reads 0.
- Fill the buffer, assert rst_i mid-stream for 1 cycle -> dp_valid_o=0, busy_o=0, evt_ready_o=1, counters 0, map back to identity.
